// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if
//   Bundles the switch-facing signals of the debouncer so the board-pin side
//   and the downstream consumer connect through one port.
//
//   Parameter
//     WIDTH       number of switch/button channels
//
//   Signals
//     sw_raw      raw, asynchronous, bouncing switch levels (into debouncer)
//     sw_db       debounced levels (out of debouncer)
//     sw_changed  one-cycle pulse when any sw_db bit changes
//     sw_rise     per-bit one-cycle pulse on a 0->1 change of sw_db
//     sw_fall     per-bit one-cycle pulse on a 1->0 change of sw_db
//
//   Modports
//     master      environment side: drives sw_raw, observes the results
//     slave       debouncer side: samples sw_raw, drives the results
interface switch_debouncer_if #(
  parameter int WIDTH = 5
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic             sw_changed;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_changed,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_changed,
    output sw_rise,
    output sw_fall
  );

endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Multi-channel switch debouncer. Every raw switch bit is synchronized
//   through two flops, then a per-channel down-stream counter measures how
//   long the synchronized level has differed from the accepted (debounced)
//   level. A new level is accepted only after STABLE_CYCLES consecutive
//   differing samples; any sample matching the accepted level throws away
//   the count.
//
//   Parameters
//     WIDTH          number of independent channels
//     STABLE_CYCLES  consecutive synchronized samples required for a new
//                    level to be accepted (2 .. 2**20)
//
//   Ports
//     clk            system clock, rising edge
//     rst            asynchronous, active-high reset
//     sw_if.slave    sw_raw in; sw_db, sw_changed, sw_rise, sw_fall out
//
//   Build option
//     SWITCH_DEBOUNCER_EDGE_EN
//       defined   -> sw_rise / sw_fall are registered per-bit pulses that
//                    coincide with the first cycle of the new sw_db value
//       undefined -> sw_rise / sw_fall are tied to zero, no flops
//     sw_db and sw_changed behave identically in both builds.
//
//   Timing
//     A raw level captured by the first synchronizer flop on edge N appears
//     on sw_db after edge N + STABLE_CYCLES + 1 (i.e. on the
//     (STABLE_CYCLES+2)-th edge counting edge N as the first).
module switch_debouncer #(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 65536
) (
  input  logic           clk,
  input  logic           rst,
  switch_debouncer_if.slave sw_if
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  // Terminal count: the sample that would make the run STABLE_CYCLES long.
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // ---------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= sw_if.sw_raw;
      sync_s2 <= sync_s1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel stability counters and accepted level
  // ---------------------------------------------------------------------
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_nxt;

  always_comb begin
    db_nxt = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (sync_s2[i] == db_q[i]) begin
        // Agreement with the accepted level: no partial credit is kept.
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        db_nxt[i]  = sync_s2[i];
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] < CNT_TERM) begin
        cnt_nxt[i] = cnt_q[i] + CNT_ONE;
      end else begin
        // Unreachable while the counter stays bounded; clearing here keeps
        // the counter from ever wrapping even if it were corrupted.
        cnt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      db_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
      db_q <= db_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Change pulse: registered from the next-state compare so it is high in
  // exactly the cycle the new sw_db value first appears. Several channels
  // accepting on one edge still produce a single pulse.
  // ---------------------------------------------------------------------
  logic changed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |(db_nxt ^ db_q);
    end
  end

  assign sw_if.sw_db      = db_q;
  assign sw_if.sw_changed = changed_q;

  // ---------------------------------------------------------------------
  // Optional per-bit edge pulses
  // ---------------------------------------------------------------------
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= db_nxt & ~db_q;
      fall_q <= ~db_nxt & db_q;
    end
  end

  assign sw_if.sw_rise = rise_q;
  assign sw_if.sw_fall = fall_q;
`else
  assign sw_if.sw_rise = '0;
  assign sw_if.sw_fall = '0;
`endif

endmodule
